rtc_bus_scheduler: RTL and testbench

- Sole owner of the multiplexed address/data bus to the external RTC (CS, RD, WR, A_D, DIR_DATO).
- Arbitrates between three requesters: init sequencer, programming writer, and periodic read-refresh.
- Runs each granted request as one address-phase plus data-phase transaction with parameterised strobe timing.
- Sits between the general control state machine / data blocks and the pad-level tristate buffer.

---
 rtl/rtc_bus_pkg.sv | 43 ++++
 rtl/rtc_bus_scheduler_timer.sv | 33 +++
 rtl/rtc_bus_scheduler.sv | 212 +++++++++++++++++++++
 tb/tb_rtc_bus_scheduler.sv | 389 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rtc_bus_pkg.sv
// Shared types and constants for the RTC multiplexed-bus scheduler.
package rtc_bus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR_SETUP,
    ST_ADDR,
    ST_ADDR_HOLD,
    ST_DATA,
    ST_DATA_HOLD,
    ST_RECOVER
  } state_e;

  typedef enum logic [1:0] {
    REQ_INI,
    REQ_WR,
    REQ_RD
  } req_id_e;

  localparam int unsigned T_SETUP_DEF    = 1;
  localparam int unsigned T_ADDR_DEF     = 7;
  localparam int unsigned T_HOLD_DEF     = 2;
  localparam int unsigned T_DATA_DEF     = 7;
  localparam int unsigned T_REC_DEF      = 4;
  localparam int unsigned MAX_STARVE_DEF = 3;
  localparam int unsigned CW_DEF         = 4;

  localparam logic [7:0] RTC_REG_SEC        = 8'h21;
  localparam logic [7:0] RTC_REG_MIN        = 8'h22;
  localparam logic [7:0] RTC_REG_HOUR       = 8'h23;
  localparam logic [7:0] RTC_REG_DAY        = 8'h24;
  localparam logic [7:0] RTC_REG_MONTH      = 8'h25;
  localparam logic [7:0] RTC_REG_YEAR       = 8'h26;
  localparam logic [7:0] RTC_REG_TMR_SEC    = 8'h41;
  localparam logic [7:0] RTC_REG_TMR_MIN    = 8'h42;
  localparam logic [7:0] RTC_REG_TMR_HOUR   = 8'h43;
  localparam logic [7:0] RTC_REG_CMD_STATUS = 8'hF0;

  function automatic logic phase_drives_addr(input state_e s);
    return (s == ST_ADDR_SETUP) || (s == ST_ADDR) || (s == ST_ADDR_HOLD);
  endfunction

endpackage

// File: rtl/rtc_bus_scheduler_timer.sv
// Loadable down-counter that paces each bus phase; zero marks the phase's last cycle.
module rtc_phase_timer #(
  parameter int unsigned CW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  output logic          zero
);

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (count_q != '0) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/rtc_bus_scheduler.sv
// Arbitrates init/program/refresh requesters onto the RTC address/data bus and sequences each transaction.
module rtc_bus_scheduler
  import rtc_bus_pkg::*;
#(
  parameter int unsigned T_SETUP    = T_SETUP_DEF,
  parameter int unsigned T_ADDR     = T_ADDR_DEF,
  parameter int unsigned T_HOLD     = T_HOLD_DEF,
  parameter int unsigned T_DATA     = T_DATA_DEF,
  parameter int unsigned T_REC      = T_REC_DEF,
  parameter int unsigned MAX_STARVE = MAX_STARVE_DEF,
  parameter int unsigned CW         = CW_DEF
) (
  input  logic       reloj,
  input  logic       resetM,
  input  logic       enable,
  input  logic       req_ini,
  input  logic       req_wr,
  input  logic       req_rd,
  input  logic [7:0] addr_ini,
  input  logic [7:0] addr_wr,
  input  logic [7:0] addr_rd,
  input  logic [7:0] wdata_ini,
  input  logic [7:0] wdata_wr,
  output logic       gnt_ini,
  output logic       gnt_wr,
  output logic       gnt_rd,
  output logic       done_ini,
  output logic       done_wr,
  output logic       done_rd,
  output logic [7:0] rdata,
  output logic       busy,
  output logic       CS,
  output logic       RD,
  output logic       WR,
  output logic       A_D,
  output logic [7:0] dir_dato_o,
  output logic       dir_dato_oe,
  input  logic [7:0] dir_dato_i
);

  localparam int unsigned SW = $clog2(MAX_STARVE + 2);

  state_e        state_q, state_d;
  req_id_e       owner_q, owner_d;
  logic          is_rd_q, is_rd_d;
  logic [7:0]    addr_q, addr_d;
  logic [7:0]    wdata_q, wdata_d;
  logic [7:0]    bus_q, bus_d;
  logic [7:0]    rdata_q, rdata_d;
  logic [SW-1:0] starve_q, starve_d;
  logic          cs_q, cs_d, rd_q, rd_d, wr_q, wr_d, ad_q, ad_d, oe_q, oe_d;
  logic          done_ini_q, done_ini_d, done_wr_q, done_wr_d, done_rd_q, done_rd_d;
  logic          gnt_ini_c, gnt_wr_c, gnt_rd_c;
  logic          tmr_load, tmr_zero;
  logic [CW-1:0] tmr_val;

  rtc_phase_timer #(.CW(CW)) u_timer (
    .clk      (reloj),
    .rst_n    (resetM),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    is_rd_d    = is_rd_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    starve_d   = starve_q;
    done_ini_d = 1'b0;
    done_wr_d  = 1'b0;
    done_rd_d  = 1'b0;
    gnt_ini_c  = 1'b0;
    gnt_wr_c   = 1'b0;
    gnt_rd_c   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (enable && (req_ini || req_wr || req_rd)) begin
          state_d = ST_ADDR_SETUP;
          // A starved read pre-empts both writers; otherwise fixed ini > wr > rd.
          if (req_rd && ((starve_q == SW'(MAX_STARVE)) || !(req_ini || req_wr))) begin
            owner_d  = REQ_RD;
            is_rd_d  = 1'b1;
            addr_d   = addr_rd;
            wdata_d  = '0;
            gnt_rd_c = 1'b1;
            starve_d = '0;
          end else begin
            is_rd_d = 1'b0;
            if (req_ini) begin
              owner_d   = REQ_INI;
              addr_d    = addr_ini;
              wdata_d   = wdata_ini;
              gnt_ini_c = 1'b1;
            end else begin
              owner_d  = REQ_WR;
              addr_d   = addr_wr;
              wdata_d  = wdata_wr;
              gnt_wr_c = 1'b1;
            end
            if (req_rd && (starve_q != SW'(MAX_STARVE))) begin
              starve_d = starve_q + SW'(1);
            end
          end
        end
      end
      ST_ADDR_SETUP: if (tmr_zero) state_d = ST_ADDR;
      ST_ADDR:       if (tmr_zero) state_d = ST_ADDR_HOLD;
      ST_ADDR_HOLD:  if (tmr_zero) state_d = ST_DATA;
      ST_DATA: begin
        if (tmr_zero) begin
          state_d = ST_DATA_HOLD;
          if (is_rd_q) rdata_d = dir_dato_i;
        end
      end
      ST_DATA_HOLD:  if (tmr_zero) state_d = ST_RECOVER;
      ST_RECOVER: begin
        if (tmr_zero) begin
          state_d    = ST_IDLE;
          done_ini_d = (owner_q == REQ_INI);
          done_wr_d  = (owner_q == REQ_WR);
          done_rd_d  = (owner_q == REQ_RD);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    tmr_load = (state_d != state_q);
    case (state_d)
      ST_ADDR_SETUP: tmr_val = CW'(T_SETUP - 1);
      ST_ADDR:       tmr_val = CW'(T_ADDR - 1);
      ST_ADDR_HOLD:  tmr_val = CW'(T_HOLD - 1);
      ST_DATA:       tmr_val = CW'(T_DATA - 1);
      ST_DATA_HOLD:  tmr_val = CW'(T_HOLD - 1);
      ST_RECOVER:    tmr_val = CW'(T_REC - 1);
      default:       tmr_val = '0;
    endcase

    // Pins are decoded from the next state so they change on the same edge as the state.
    cs_d = !((state_d == ST_ADDR) || (state_d == ST_DATA));
    wr_d = !((state_d == ST_ADDR) || ((state_d == ST_DATA) && !is_rd_d));
    rd_d = !((state_d == ST_DATA) && is_rd_d);
    ad_d = !phase_drives_addr(state_d);
    oe_d = 1'b0;
    bus_d = '0;
    if (phase_drives_addr(state_d)) begin
      oe_d  = 1'b1;
      bus_d = addr_d;
    end else if (((state_d == ST_DATA) || (state_d == ST_DATA_HOLD)) && !is_rd_d) begin
      oe_d  = 1'b1;
      bus_d = wdata_d;
    end
  end

  always_ff @(posedge reloj or negedge resetM) begin
    if (!resetM) begin
      state_q    <= ST_IDLE;
      owner_q    <= REQ_INI;
      is_rd_q    <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      bus_q      <= '0;
      rdata_q    <= '0;
      starve_q   <= '0;
      cs_q       <= 1'b1;
      rd_q       <= 1'b1;
      wr_q       <= 1'b1;
      ad_q       <= 1'b1;
      oe_q       <= 1'b0;
      done_ini_q <= 1'b0;
      done_wr_q  <= 1'b0;
      done_rd_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      is_rd_q    <= is_rd_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      bus_q      <= bus_d;
      rdata_q    <= rdata_d;
      starve_q   <= starve_d;
      cs_q       <= cs_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      ad_q       <= ad_d;
      oe_q       <= oe_d;
      done_ini_q <= done_ini_d;
      done_wr_q  <= done_wr_d;
      done_rd_q  <= done_rd_d;
    end
  end

  assign gnt_ini     = gnt_ini_c;
  assign gnt_wr      = gnt_wr_c;
  assign gnt_rd      = gnt_rd_c;
  assign done_ini    = done_ini_q;
  assign done_wr     = done_wr_q;
  assign done_rd     = done_rd_q;
  assign rdata       = rdata_q;
  assign busy        = (state_q != ST_IDLE);
  assign CS          = cs_q;
  assign RD          = rd_q;
  assign WR          = wr_q;
  assign A_D         = ad_q;
  assign dir_dato_o  = bus_q;
  assign dir_dato_oe = oe_q;

endmodule

// File: tb/tb_rtc_bus_scheduler.sv
// Self-checking bench for rtc_bus_scheduler: phase-table pin model plus transaction-level arbitration model.
module tb_rtc_bus_scheduler;
  import rtc_bus_pkg::*;

  localparam int TS = 1, TA = 7, TH = 2, TD = 7, TR = 4, MS = 3;
  localparam int TOTAL = TS + TA + TH + TD + TH + TR;
  localparam int D_LO = TS + TA + TH;
  localparam int D_HI = D_LO + TD;

  logic reloj = 1'b0;
  logic resetM, enable, req_ini, req_wr, req_rd;
  logic [7:0] addr_ini, addr_wr, addr_rd, wdata_ini, wdata_wr, dir_dato_i;
  logic gnt_ini, gnt_wr, gnt_rd, done_ini, done_wr, done_rd, busy;
  logic CS, RD, WR, A_D, dir_dato_oe;
  logic [7:0] rdata, dir_dato_o;

  int unsigned n_tests = 0;
  int unsigned n_fail = 0;
  int glog[$];
  int dlog[$];

  always #5 reloj = ~reloj;

  rtc_bus_scheduler #(
    .T_SETUP(TS), .T_ADDR(TA), .T_HOLD(TH), .T_DATA(TD), .T_REC(TR),
    .MAX_STARVE(MS), .CW(4)
  ) dut (
    .reloj(reloj), .resetM(resetM), .enable(enable),
    .req_ini(req_ini), .req_wr(req_wr), .req_rd(req_rd),
    .addr_ini(addr_ini), .addr_wr(addr_wr), .addr_rd(addr_rd),
    .wdata_ini(wdata_ini), .wdata_wr(wdata_wr),
    .gnt_ini(gnt_ini), .gnt_wr(gnt_wr), .gnt_rd(gnt_rd),
    .done_ini(done_ini), .done_wr(done_wr), .done_rd(done_rd),
    .rdata(rdata), .busy(busy),
    .CS(CS), .RD(RD), .WR(WR), .A_D(A_D),
    .dir_dato_o(dir_dato_o), .dir_dato_oe(dir_dato_oe), .dir_dato_i(dir_dato_i)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge reloj);
    #1;
  endtask

  // Expected {cs,rd,wr,ad,oe} and bus for cycle k of a transaction (k=0 is the first setup cycle).
  function automatic logic [12:0] exp_pins(input int k, input bit is_rd,
                                           input logic [7:0] a, input logic [7:0] w);
    logic cs, rd, wr, ad, oe;
    logic [7:0] bus;
    cs = 1; rd = 1; wr = 1; ad = 1; oe = 0; bus = 8'h00;
    if (k < TS) begin
      ad = 0; oe = 1; bus = a;
    end else if (k < TS + TA) begin
      cs = 0; wr = 0; ad = 0; oe = 1; bus = a;
    end else if (k < D_LO) begin
      ad = 0; oe = 1; bus = a;
    end else if (k < D_HI) begin
      cs = 0;
      if (is_rd) rd = 0;
      else begin wr = 0; oe = 1; bus = w; end
    end else if (k < D_HI + TH) begin
      if (!is_rd) begin oe = 1; bus = w; end
    end
    return {cs, rd, wr, ad, oe, bus};
  endfunction

  task automatic set_req(input int who, input logic v);
    case (who)
      0: req_ini = v;
      1: req_wr = v;
      default: req_rd = v;
    endcase
  endtask

  task automatic set_bus_in(input int who, input logic [7:0] a, input logic [7:0] w);
    case (who)
      0: begin addr_ini = a; wdata_ini = w; end
      1: begin addr_wr = a; wdata_wr = w; end
      default: addr_rd = a;
    endcase
  endtask

  task automatic do_reset();
    resetM = 1'b0;
    tick();
    tick();
    resetM = 1'b1;
    tick();
  endtask

  // Single transaction from IDLE; scramble drops req, changes inputs and re-raises req mid-flight.
  task automatic run_single(input int who, input logic [7:0] a, input logic [7:0] w,
                            input logic [7:0] rv, input bit scramble);
    logic [12:0] e;
    logic [11:0] got, want;
    bit is_rd;
    is_rd = (who == 2);
    set_bus_in(who, a, w);
    set_req(who, 1'b1);
    #1;
    n_tests++;
    if ({gnt_ini, gnt_wr, gnt_rd} !== (3'b100 >> who)) begin
      n_fail++;
      $display("FAIL gnt_single who=%0d: got %b want %b", who, {gnt_ini, gnt_wr, gnt_rd}, 3'b100 >> who);
    end
    for (int k = 0; k < TOTAL; k++) begin
      tick();
      if (scramble && k == 0) begin
        set_req(who, 1'b0);
        set_bus_in(who, ~a, ~w);
      end
      if (scramble && k == 15) set_req(who, 1'b1);
      dir_dato_i = (k >= D_LO && k < D_HI) ? rv : ~rv;
      e = exp_pins(k, is_rd, a, w);
      got  = {CS, RD, WR, A_D, dir_dato_oe, busy, gnt_ini, gnt_wr, gnt_rd, done_ini, done_wr, done_rd};
      want = {e[12:8], 1'b1, 6'b000000};
      n_tests++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL pins_k%0d who=%0d: got %b want %b", k, who, got, want);
      end
      if (e[8]) begin
        n_tests++;
        if (dir_dato_o !== e[7:0]) begin
          n_fail++;
          $display("FAIL bus_k%0d who=%0d: got %h want %h", k, who, dir_dato_o, e[7:0]);
        end
      end
    end
    tick();
    n_tests++;
    if ({busy, done_ini, done_wr, done_rd, CS, RD, WR, A_D, dir_dato_oe} !== {1'b0, 3'b100 >> who, 5'b11110}) begin
      n_fail++;
      $display("FAIL done_single who=%0d: got %b want %b", who,
               {busy, done_ini, done_wr, done_rd, CS, RD, WR, A_D, dir_dato_oe}, {1'b0, 3'b100 >> who, 5'b11110});
    end
    if (is_rd) begin
      n_tests++;
      if (rdata !== rv) begin
        n_fail++;
        $display("FAIL rdata_single: got %h want %h", rdata, rv);
      end
    end
    set_req(who, 1'b0);
  endtask

  task automatic test_reset();
    resetM = 1'b0;
    #1;
    n_tests++;
    if ({CS, RD, WR, A_D, dir_dato_oe, busy, gnt_ini, gnt_wr, gnt_rd, done_ini, done_wr, done_rd, dir_dato_o, rdata}
        !== {4'b1111, 8'b0, 16'h0000}) begin
      n_fail++;
      $display("FAIL reset_state: got %b %h %h", {CS, RD, WR, A_D, dir_dato_oe, busy, gnt_ini, gnt_wr, gnt_rd,
               done_ini, done_wr, done_rd}, dir_dato_o, rdata);
    end
    tick();
    resetM = 1'b1;
    tick();
  endtask

  task automatic test_single_write();
    run_single(1, RTC_REG_SEC, 8'h45, 8'h00, 1'b0);
    for (int i = 0; i < 3; i++) run_single(1, 8'($urandom), 8'($urandom), 8'($urandom), 1'b1);
  endtask

  task automatic test_single_read();
    run_single(2, RTC_REG_HOUR, 8'h00, 8'h59, 1'b0);
    for (int i = 0; i < 3; i++) run_single(2, 8'($urandom), 8'($urandom), 8'($urandom), 1'b1);
  endtask

  task automatic test_single_ini();
    for (int i = 0; i < 2; i++) run_single(0, 8'($urandom), 8'($urandom), 8'($urandom), i[0]);
  endtask

  task automatic test_mid_reset();
    logic [7:0] a, w;
    a = 8'($urandom); w = 8'($urandom);
    addr_wr = a; wdata_wr = w; req_wr = 1'b1;
    #1;
    for (int k = 0; k <= 12; k++) tick();
    n_tests++;
    if ({CS, RD, WR, A_D, dir_dato_oe} !== 5'b01011) begin
      n_fail++;
      $display("FAIL midreset_pre: got %b want %b", {CS, RD, WR, A_D, dir_dato_oe}, 5'b01011);
    end
    resetM = 1'b0;
    #1;
    n_tests++;
    if ({CS, RD, WR, A_D, dir_dato_oe, busy, done_ini, done_wr, done_rd} !== 9'b111100000) begin
      n_fail++;
      $display("FAIL midreset_abort: got %b want %b",
               {CS, RD, WR, A_D, dir_dato_oe, busy, done_ini, done_wr, done_rd}, 9'b111100000);
    end
    tick();
    resetM = 1'b1;
    #1;
    n_tests++;
    if ({gnt_ini, gnt_wr, gnt_rd, done_wr} !== 4'b0100) begin
      n_fail++;
      $display("FAIL midreset_regrant: got %b want %b", {gnt_ini, gnt_wr, gnt_rd, done_wr}, 4'b0100);
    end
    tick();
    n_tests++;
    if ({CS, WR, A_D, dir_dato_oe, busy, dir_dato_o} !== {5'b11011, a}) begin
      n_fail++;
      $display("FAIL midreset_setup: got %b %h want %b %h", {CS, WR, A_D, dir_dato_oe, busy}, dir_dato_o, 5'b11011, a);
    end
    for (int k = 1; k < TOTAL; k++) tick();
    tick();
    n_tests++;
    if ({busy, done_ini, done_wr, done_rd} !== 4'b0010) begin
      n_fail++;
      $display("FAIL midreset_done: got %b want %b", {busy, done_ini, done_wr, done_rd}, 4'b0010);
    end
    req_wr = 1'b0;
  endtask

  task automatic test_enable();
    int seen;
    enable = 1'b0;
    addr_ini = 8'($urandom); wdata_ini = 8'($urandom); req_ini = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_tests++;
      if ({gnt_ini, busy} !== 2'b00) begin
        n_fail++;
        $display("FAIL enable_hold_%0d: got %b want %b", i, {gnt_ini, busy}, 2'b00);
      end
    end
    enable = 1'b1;
    #1;
    n_tests++;
    if (gnt_ini !== 1'b1) begin
      n_fail++;
      $display("FAIL enable_grant: got %b want 1", gnt_ini);
    end
    seen = -1;
    for (int c = 1; c <= 40 && seen < 0; c++) begin
      tick();
      if (done_ini === 1'b1) seen = c;
    end
    n_tests++;
    if (seen != TOTAL + 1) begin
      n_fail++;
      $display("FAIL enable_done_latency: got %0d want %0d", seen, TOTAL + 1);
    end
    req_ini = 1'b0;
  endtask

  // Requesters hold req until their done; model tracks idle/busy time and arbitration rules.
  task automatic run_arb(input int n_ini, input int n_wr, input int n_rd, input bit rand_en,
                         input int max_cycles);
    int rem[3];
    int cnt, owner, pend, w, cyc, m_starve;
    logic [7:0] rv;
    logic [2:0] eg, ed;
    logic eb;
    bit fin;
    glog.delete();
    dlog.delete();
    enable = 1'b1;
    req_ini = 0; req_wr = 0; req_rd = 0;
    do_reset();
    m_starve = 0;
    rem[0] = n_ini; rem[1] = n_wr; rem[2] = n_rd;
    rv = 8'($urandom);
    dir_dato_i = rv;
    for (int i = 0; i < 3; i++) begin
      set_bus_in(i, 8'($urandom), 8'($urandom));
      set_req(i, rem[i] > 0);
    end
    cnt = 0; pend = -1; owner = -1; cyc = 0;
    fin = (n_ini + n_wr + n_rd == 0);
    while (!fin && cyc < max_cycles) begin
      if (cyc > 0) tick();
      if (rand_en) enable = ($urandom_range(0, 3) != 0);
      eg = 3'b000; ed = 3'b000;
      if (cnt > 0) begin
        eb = 1'b1;
        cnt--;
        if (cnt == 0) pend = owner;
      end else begin
        eb = 1'b0;
        if (pend >= 0) begin
          ed = 3'b100 >> pend;
          rem[pend]--;
          set_req(pend, rem[pend] > 0);
          set_bus_in(pend, 8'($urandom), 8'($urandom));
          dlog.push_back(cyc);
          if (pend == 2) begin
            n_tests++;
            if (rdata !== rv) begin
              n_fail++;
              $display("FAIL arb_rdata cyc=%0d: got %h want %h", cyc, rdata, rv);
            end
          end
          pend = -1;
        end
        w = -1;
        if (enable && (req_ini || req_wr || req_rd)) begin
          if (req_rd && (m_starve == MS || !(req_ini || req_wr))) w = 2;
          else if (req_ini) w = 0;
          else w = 1;
        end
        if (w == 2) m_starve = 0;
        else if (w >= 0 && req_rd) m_starve++;
        if (w >= 0) begin
          eg = 3'b100 >> w;
          owner = w;
          cnt = TOTAL;
          glog.push_back(w);
        end
      end
      #1;
      n_tests++;
      if ({busy, gnt_ini, gnt_wr, gnt_rd, done_ini, done_wr, done_rd} !== {eb, eg, ed}) begin
        n_fail++;
        $display("FAIL arb_cyc%0d: got b=%b g=%b d=%b want b=%b g=%b d=%b", cyc,
                 busy, {gnt_ini, gnt_wr, gnt_rd}, {done_ini, done_wr, done_rd}, eb, eg, ed);
      end
      cyc++;
      fin = (rem[0] + rem[1] + rem[2] == 0) && (cnt == 0) && (pend < 0);
    end
    n_tests++;
    if (!fin) begin
      n_fail++;
      $display("FAIL arb_timeout: got %0d cycles, required completion within %0d", cyc, max_cycles);
    end
    req_ini = 0; req_wr = 0; req_rd = 0;
    enable = 1'b1;
  endtask

  task automatic test_simultaneous();
    run_arb(1, 1, 1, 1'b0, 200);
    n_tests++;
    if (glog.size() != 3 || glog[0] != 0 || glog[1] != 1 || glog[2] != 2) begin
      n_fail++;
      $display("FAIL simul_order: got %p want '{0,1,2}", glog);
    end
    n_tests++;
    if (dlog.size() != 3 || dlog[1] - dlog[0] != TOTAL + 1 || dlog[2] - dlog[1] != TOTAL + 1) begin
      n_fail++;
      $display("FAIL simul_spacing: got %p want spacing %0d", dlog, TOTAL + 1);
    end
  endtask

  task automatic test_starvation();
    int pat[8];
    pat = '{1, 1, 1, 2, 1, 1, 1, 2};
    run_arb(0, 8, 2, 1'b0, 400);
    for (int i = 0; i < 8; i++) begin
      n_tests++;
      if (i >= glog.size() || glog[i] != pat[i]) begin
        n_fail++;
        $display("FAIL starve_grant%0d: got %0d want %0d", i, (i < glog.size()) ? glog[i] : -1, pat[i]);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 4; i++)
      run_arb($urandom_range(0, 3), $urandom_range(0, 4), $urandom_range(1, 4), 1'b1, 800);
  endtask

  initial begin
    resetM = 1'b0; enable = 1'b1;
    req_ini = 0; req_wr = 0; req_rd = 0;
    addr_ini = 0; addr_wr = 0; addr_rd = 0; wdata_ini = 0; wdata_wr = 0; dir_dato_i = 0;
    tick();
    test_reset();
    test_single_write();
    test_single_read();
    test_single_ini();
    test_mid_reset();
    test_enable();
    test_simultaneous();
    test_starvation();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
